multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Multicycle LEGv8 control unit; successor to the single-cycle combinational control unit.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, holds an internal NZCV flags register and evaluates B.cond from it.
- Waits on instruction and data memory ready handshakes with a bounded timeout; traps on illegal opcodes.
- Sits between the instruction register/PC logic and the datapath (register file, ALU, SEU, data memory).

Parameters:
- ALUOP_W, 4, width of ALUOp.
- MEM_TIMEOUT, 15, maximum wait cycles on IMReady/DMReady before TRAP (1..255).
- FLAGS_RST, 4'b0000, reset value of the NZCV register.

Ports:
- Clk  in  1  clock, rising edge.
- nRst  in  1  asynchronous active-low reset.
- OpCode  in  11  instruction[31:21]; sampled when IRWr=1.
- Cond  in  4  instruction[3:0]; sampled with OpCode.
- ALUFlags  in  4  NZCV from the ALU, valid in EXEC.
- IMReady  in  1  instruction memory ready.
- DMReady  in  1  data memory ready.
- IMRd  out  1  instruction fetch request.
- IRWr  out  1  instruction register load strobe.
- PCWr  out  1  PC update strobe.
- PCSrc  out  2  00 PC+4, 01 branch target, 10 register.
- DMRd  out  1  data memory read request.
- DMWr  out  1  data memory write request.
- RFDataWrScr  out  2  00 ALU, 01 memory, 10 PC+4.
- ALUOp  out  ALUOP_W  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 PASS-B.
- ALUBScr  out  1  0 register, 1 SEU.
- SEUScr  out  2  00 ALU-imm, 01 D-offset, 10 B-offset, 11 CB-offset.
- RFWr  out  1  register file write strobe.
- RegWrSrc  out  1  1 selects X30 (BL).
- RegRd2Src  out  1  1 selects Rt (STUR/CBZ).
- FlagsQ  out  4  NZCV register.
- State  out  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 7 TRAP.
- Illegal  out  1  high while in TRAP.

Behaviour:
- Reset (async, nRst=0): State=FETCH, FlagsQ=FLAGS_RST, opcode latch=0, wait counter=0. All strobes and requests are 0 except IMRd=1 once reset is released. Reset mid-instruction aborts the instruction with no PCWr and no RFWr.
- Control outputs are Moore outputs decoded from State and the latched OpCode/Cond.
- Decode classes:
  - R-type: ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000, ADDS 10101011000, SUBS 11101011000.
  - I-type: ADDI 1001000100x, SUBI 1101000100x.
  - Memory: LDUR 11111000010, STUR 11111000000.
  - Compare-branch: CBZ 10110100xxx, CBNZ 10110101xxx.
  - Branch: B 000101xxxxx, BL 100101xxxxx, B.cond 01010100xxx, BR 11010110000.
  - Anything else is illegal.
- FETCH:
  - IMRd=1; counter increments each cycle IMReady=0.
  - On IMReady=1: IRWr=1 for that cycle, latch OpCode/Cond, go to DECODE.
  - Counter reaching MEM_TIMEOUT goes to TRAP.
- DECODE (1 cycle): illegal goes to TRAP; otherwise go to EXEC.
- EXEC (1 cycle), by class:
  - R/I: drive ALUOp/ALUBScr/SEUScr, go to WB. ADDS/SUBS load FlagsQ<=ALUFlags at the end of this cycle; no other instruction writes FlagsQ.
  - LDUR/STUR: ALUOp=ADD, ALUBScr=1, SEUScr=01, go to MEM.
  - CBZ/CBNZ: ALUOp=PASS-B, RegRd2Src=1, SEUScr=11. Taken when ALUFlags.Z (CBZ) or !ALUFlags.Z (CBNZ). PCWr=1, PCSrc=01 if taken else 00; go to FETCH.
  - B: PCWr=1, PCSrc=01; go to FETCH.
  - BR: PCWr=1, PCSrc=10; go to FETCH.
  - B.cond: evaluate Cond against FlagsQ (ARM encoding: EQ, NE, HS, LO, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 treated as AL). PCWr=1, PCSrc=01 if taken else 00.
  - BL: RFWr=1, RegWrSrc=1, RFDataWrScr=10, PCWr=1, PCSrc=01 in the same cycle; go to FETCH.
- MEM:
  - LDUR: DMRd=1 held until DMReady=1, then go to WB.
  - STUR: DMWr=1 and RegRd2Src=1 held until DMReady=1; PCWr=1 (PCSrc=00) in the DMReady cycle; go to FETCH.
  - Timeout as in FETCH; the counter clears on every state entry.
- WB (1 cycle): RFWr=1, RFDataWrScr=01 for LDUR else 00, PCWr=1, PCSrc=00; go to FETCH.
- TRAP: all strobes 0, Illegal=1, FlagsQ held; exit only via reset.
- Zero-wait latencies:
  - R/I: 4 cycles.
  - LDUR: 5 cycles.
  - STUR: 4 cycles.
  - Branches: 3 cycles.
- PCWr and RFWr are asserted at most once per instruction.

Test Plan:
- Reset, then ADDS (10101011000) with IMReady=1 and ALUFlags=4'b0100 -> states 0,1,2,4. FlagsQ=0100 after EXEC. RFWr=1 and PCWr=1 (PCSrc=00) only in WB.
- After that, B.cond Cond=0000 (EQ) with FlagsQ.Z=1 -> PCWr=1, PCSrc=01 in EXEC. Repeat with Cond=0001 (NE) -> PCSrc=00.
- LDUR with DMReady low 3 cycles -> DMRd held 4 cycles, then WB with RFDataWrScr=01. Total 8 cycles.
- STUR with DMReady never high, MEM_TIMEOUT=15 -> TRAP after 15 MEM wait cycles. Illegal=1, DMWr=0 in TRAP, no PCWr.
- Illegal opcode 11110010000 -> DECODE to TRAP, Illegal=1. Then nRst low mid-state -> State=FETCH immediately, FlagsQ=0000.
- BL -> EXEC asserts RFWr, RegWrSrc=1, RFDataWrScr=10, PCWr with PCSrc=01. CBNZ with ALUFlags.Z=0 -> taken, PCSrc=01.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle LEGv8 control unit: sequences FETCH/DECODE/EXEC/MEM/WB, keeps the NZCV
// flags register, evaluates B.cond, and traps on illegal opcodes or memory timeouts.
module multicycle_control_unit #(
  parameter int         ALUOP_W     = 4,
  parameter int         MEM_TIMEOUT = 15,
  parameter logic [3:0] FLAGS_RST   = 4'b0000
) (
  input  logic               Clk,
  input  logic               nRst,
  input  logic [10:0]        OpCode,
  input  logic [3:0]         Cond,
  input  logic [3:0]         ALUFlags,
  input  logic               IMReady,
  input  logic               DMReady,
  output logic               IMRd,
  output logic               IRWr,
  output logic               PCWr,
  output logic [1:0]         PCSrc,
  output logic               DMRd,
  output logic               DMWr,
  output logic [1:0]         RFDataWrScr,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               ALUBScr,
  output logic [1:0]         SEUScr,
  output logic               RFWr,
  output logic               RegWrSrc,
  output logic               RegRd2Src,
  output logic [3:0]         FlagsQ,
  output logic [2:0]         State,
  output logic               Illegal
);

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_TRAP   = 3'd7;

  localparam logic [3:0] CLS_ILL = 4'd0;
  localparam logic [3:0] CLS_R   = 4'd1;
  localparam logic [3:0] CLS_I   = 4'd2;
  localparam logic [3:0] CLS_LD  = 4'd3;
  localparam logic [3:0] CLS_ST  = 4'd4;
  localparam logic [3:0] CLS_CB  = 4'd5;
  localparam logic [3:0] CLS_B   = 4'd6;
  localparam logic [3:0] CLS_BL  = 4'd7;
  localparam logic [3:0] CLS_BC  = 4'd8;
  localparam logic [3:0] CLS_BR  = 4'd9;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]  state_r, state_next_s;
  logic [10:0] opcode_r;
  logic [3:0]  cond_r;
  logic [3:0]  flags_r;
  logic [7:0]  wait_cnt_r;
  logic [3:0]  cls_s;
  logic [2:0]  alu_op_s;
  logic        alu_b_s;
  logic [1:0]  seu_s;
  logic        sets_flags_s;
  logic        cb_taken_s;
  logic        bc_taken_s;
  logic        wait_expired_s;
  logic        irwr_s;

  function automatic logic [3:0] decode_class(input logic [10:0] op);
    logic [3:0] cls;
    casez (op)
      11'b10001011000, 11'b11001011000, 11'b10001010000,
      11'b10101010000, 11'b10101011000, 11'b11101011000: cls = CLS_R;
      11'b1001000100?, 11'b1101000100?:                  cls = CLS_I;
      11'b11111000010:                                   cls = CLS_LD;
      11'b11111000000:                                   cls = CLS_ST;
      11'b1011010????:                                   cls = CLS_CB;
      11'b000101?????:                                   cls = CLS_B;
      11'b100101?????:                                   cls = CLS_BL;
      11'b01010100???:                                   cls = CLS_BC;
      11'b11010110000:                                   cls = CLS_BR;
      default:                                           cls = CLS_ILL;
    endcase
    return cls;
  endfunction

  // ARM condition codes over NZCV; 1110 and 1111 both mean always
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      4'b0000: r = z;
      4'b0001: r = !z;
      4'b0010: r = cy;
      4'b0011: r = !cy;
      4'b0100: r = n;
      4'b0101: r = !n;
      4'b0110: r = v;
      4'b0111: r = !v;
      4'b1000: r = cy && !z;
      4'b1001: r = !cy || z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = !z && (n == v);
      4'b1101: r = z || (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign cls_s          = decode_class(opcode_r);
  assign sets_flags_s   = (opcode_r == 11'b10101011000) || (opcode_r == 11'b11101011000);
  assign cb_taken_s     = opcode_r[3] ? !ALUFlags[2] : ALUFlags[2];
  assign bc_taken_s     = cond_pass(cond_r, flags_r);
  assign wait_expired_s = (wait_cnt_r == WAIT_LAST);
  assign irwr_s         = nRst && (state_r == ST_FETCH) && IMReady;

  assign State   = state_r;
  assign FlagsQ  = flags_r;
  assign Illegal = (state_r == ST_TRAP);

  // State register
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) state_r <= ST_FETCH;
    else       state_r <= state_next_s;
  end

  // Instruction latch, flags register and ready-wait counter
  always_ff @(posedge Clk or negedge nRst) begin
    if (!nRst) begin
      opcode_r   <= 11'd0;
      cond_r     <= 4'd0;
      flags_r    <= FLAGS_RST;
      wait_cnt_r <= 8'd0;
    end else begin
      if (irwr_s) begin
        opcode_r <= OpCode;
        cond_r   <= Cond;
      end
      if ((state_r == ST_EXEC) && sets_flags_s) flags_r <= ALUFlags;
      if (state_next_s != state_r)                             wait_cnt_r <= 8'd0;
      else if ((state_r == ST_FETCH) || (state_r == ST_MEM))   wait_cnt_r <= wait_cnt_r + 8'd1;
      else                                                     wait_cnt_r <= 8'd0;
    end
  end

  // Next-state decode
  always_comb begin
    state_next_s = ST_TRAP;
    case (state_r)
      ST_FETCH: begin
        if (IMReady)             state_next_s = ST_DECODE;
        else if (wait_expired_s) state_next_s = ST_TRAP;
        else                     state_next_s = ST_FETCH;
      end
      ST_DECODE: state_next_s = (cls_s == CLS_ILL) ? ST_TRAP : ST_EXEC;
      ST_EXEC: begin
        case (cls_s)
          CLS_R, CLS_I:   state_next_s = ST_WB;
          CLS_LD, CLS_ST: state_next_s = ST_MEM;
          CLS_ILL:        state_next_s = ST_TRAP;
          default:        state_next_s = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (DMReady)             state_next_s = (cls_s == CLS_LD) ? ST_WB : ST_FETCH;
        else if (wait_expired_s) state_next_s = ST_TRAP;
        else                     state_next_s = ST_MEM;
      end
      ST_WB:   state_next_s = ST_FETCH;
      ST_TRAP: state_next_s = ST_TRAP;
      default: state_next_s = ST_TRAP;
    endcase
  end

  // ALU operand controls per instruction class, held through EXEC/MEM/WB
  always_comb begin
    alu_op_s = 3'd0;
    alu_b_s  = 1'b0;
    seu_s    = 2'b00;
    case (cls_s)
      CLS_R: begin
        case (opcode_r)
          11'b11001011000, 11'b11101011000: alu_op_s = 3'd1;
          11'b10001010000:                  alu_op_s = 3'd2;
          11'b10101010000:                  alu_op_s = 3'd3;
          default:                          alu_op_s = 3'd0;
        endcase
      end
      CLS_I: begin
        alu_op_s = opcode_r[9] ? 3'd1 : 3'd0;
        alu_b_s  = 1'b1;
      end
      CLS_LD, CLS_ST: begin
        alu_b_s = 1'b1;
        seu_s   = 2'b01;
      end
      CLS_CB: begin
        alu_op_s = 3'd4;
        seu_s    = 2'b11;
      end
      CLS_BC:        seu_s = 2'b11;
      CLS_B, CLS_BL: seu_s = 2'b10;
      default:       alu_op_s = 3'd0;
    endcase
  end

  // Moore output decode from state and latched instruction
  always_comb begin
    IMRd        = 1'b0;
    IRWr        = irwr_s;
    PCWr        = 1'b0;
    PCSrc       = 2'b00;
    DMRd        = 1'b0;
    DMWr        = 1'b0;
    RFDataWrScr = 2'b00;
    ALUOp       = ALUOP_W'(3'd0);
    ALUBScr     = 1'b0;
    SEUScr      = 2'b00;
    RFWr        = 1'b0;
    RegWrSrc    = 1'b0;
    RegRd2Src   = 1'b0;
    case (state_r)
      ST_FETCH: IMRd = nRst;
      ST_EXEC: begin
        ALUOp   = ALUOP_W'(alu_op_s);
        ALUBScr = alu_b_s;
        SEUScr  = seu_s;
        case (cls_s)
          CLS_ST: RegRd2Src = 1'b1;
          CLS_CB: begin
            RegRd2Src = 1'b1;
            PCWr      = 1'b1;
            PCSrc     = cb_taken_s ? 2'b01 : 2'b00;
          end
          CLS_B: begin
            PCWr  = 1'b1;
            PCSrc = 2'b01;
          end
          CLS_BL: begin
            PCWr        = 1'b1;
            PCSrc       = 2'b01;
            RFWr        = 1'b1;
            RegWrSrc    = 1'b1;
            RFDataWrScr = 2'b10;
          end
          CLS_BC: begin
            PCWr  = 1'b1;
            PCSrc = bc_taken_s ? 2'b01 : 2'b00;
          end
          CLS_BR: begin
            PCWr  = 1'b1;
            PCSrc = 2'b10;
          end
          default: PCWr = 1'b0;
        endcase
      end
      ST_MEM: begin
        ALUOp   = ALUOP_W'(alu_op_s);
        ALUBScr = alu_b_s;
        SEUScr  = seu_s;
        DMRd      = (cls_s == CLS_LD);
        DMWr      = (cls_s == CLS_ST);
        RegRd2Src = (cls_s == CLS_ST);
        PCWr      = (cls_s == CLS_ST) && DMReady;
      end
      ST_WB: begin
        ALUOp       = ALUOP_W'(alu_op_s);
        ALUBScr     = alu_b_s;
        SEUScr      = seu_s;
        RFWr        = 1'b1;
        PCWr        = 1'b1;
        RFDataWrScr = (cls_s == CLS_LD) ? 2'b01 : 2'b00;
      end
      default: IMRd = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: linear instruction sequence with
// hand-computed expected control outputs checked by immediate assertions.
module tb_multicycle_control_unit;

  logic        Clk, nRst;
  logic [10:0] OpCode;
  logic [3:0]  Cond, ALUFlags;
  logic        IMReady, DMReady;
  logic        IMRd, IRWr, PCWr, DMRd, DMWr, ALUBScr, RFWr, RegWrSrc, RegRd2Src, Illegal;
  logic [1:0]  PCSrc, RFDataWrScr, SEUScr;
  logic [3:0]  ALUOp, FlagsQ;
  logic [2:0]  State;

  int tests = 0;
  int fails = 0;

  multicycle_control_unit dut (
    .Clk(Clk), .nRst(nRst), .OpCode(OpCode), .Cond(Cond), .ALUFlags(ALUFlags),
    .IMReady(IMReady), .DMReady(DMReady), .IMRd(IMRd), .IRWr(IRWr), .PCWr(PCWr),
    .PCSrc(PCSrc), .DMRd(DMRd), .DMWr(DMWr), .RFDataWrScr(RFDataWrScr), .ALUOp(ALUOp),
    .ALUBScr(ALUBScr), .SEUScr(SEUScr), .RFWr(RFWr), .RegWrSrc(RegWrSrc),
    .RegRd2Src(RegRd2Src), .FlagsQ(FlagsQ), .State(State), .Illegal(Illegal)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock and settle just after the edge
  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    nRst = 1'b0; OpCode = 11'd0; Cond = 4'd0; ALUFlags = 4'd0;
    IMReady = 1'b0; DMReady = 1'b0;
    #3;
    chk("rst_state", 16'(State), 16'd0);
    chk("rst_flags", 16'(FlagsQ), 16'd0);
    chk("rst_strobes", 16'({IRWr, PCWr, RFWr, DMRd, DMWr, Illegal}), 16'd0);

    // ADDS with Z set by the ALU
    nRst = 1'b1; IMReady = 1'b1; OpCode = 11'b10101011000; ALUFlags = 4'b0100;
    #1;
    chk("adds_fetch_state", 16'(State), 16'd0);
    chk("adds_fetch_imrd_irwr", 16'({IMRd, IRWr}), 16'b11);
    cyc(); IMReady = 1'b0; #1;
    chk("adds_decode", 16'(State), 16'd1);
    chk("adds_decode_wr", 16'({PCWr, RFWr}), 16'd0);
    cyc(); #1;
    chk("adds_exec", 16'(State), 16'd2);
    chk("adds_exec_alu", 16'({ALUOp, ALUBScr}), 16'b0000_0);
    chk("adds_exec_wr", 16'({PCWr, RFWr}), 16'd0);
    chk("adds_exec_flags_old", 16'(FlagsQ), 16'd0);
    cyc(); ALUFlags = 4'b0000; #1;
    chk("adds_wb", 16'(State), 16'd4);
    chk("adds_flags", 16'(FlagsQ), 16'b0100);
    chk("adds_wb_ctl", 16'({RFWr, PCWr, PCSrc, RFDataWrScr}), 16'b1_1_00_00);
    cyc(); #1;
    chk("adds_back_fetch", 16'(State), 16'd0);

    // B.EQ taken with Z=1
    IMReady = 1'b1; OpCode = 11'b01010100000; Cond = 4'b0000; #1;
    cyc(); IMReady = 1'b0; #1;
    cyc(); #1;
    chk("beq_exec", 16'(State), 16'd2);
    chk("beq_pc", 16'({PCWr, PCSrc, RFWr}), 16'b1_01_0);
    cyc(); #1;
    chk("beq_fetch", 16'(State), 16'd0);

    // B.NE not taken
    IMReady = 1'b1; Cond = 4'b0001; #1;
    cyc(); IMReady = 1'b0; #1;
    cyc(); #1;
    chk("bne_pc", 16'({PCWr, PCSrc}), 16'b1_00);
    chk("bne_flags_held", 16'(FlagsQ), 16'b0100);
    cyc(); #1;

    // LDUR with DMReady low for three MEM cycles
    IMReady = 1'b1; OpCode = 11'b11111000010; #1;
    chk("ldur_fetch", 16'(State), 16'd0);
    cyc(); IMReady = 1'b0; #1;
    cyc(); #1;
    chk("ldur_exec_alu", 16'({ALUOp, ALUBScr, SEUScr}), 16'b0000_1_01);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("ldur_mem_wait", 16'({State, DMRd, PCWr, RFWr}), 16'b011_1_0_0);
    end
    cyc(); DMReady = 1'b1; #1;
    chk("ldur_mem_ready", 16'({State, DMRd, PCWr}), 16'b011_1_0);
    cyc(); DMReady = 1'b0; #1;
    chk("ldur_wb", 16'({State, RFWr, RFDataWrScr, PCWr, PCSrc}), 16'b100_1_01_1_00);
    cyc(); #1;
    chk("ldur_done", 16'(State), 16'd0);

    // BL
    IMReady = 1'b1; OpCode = 11'b10010100000; #1;
    cyc(); IMReady = 1'b0; #1;
    cyc(); #1;
    chk("bl_exec", 16'({RFWr, RegWrSrc, RFDataWrScr, PCWr, PCSrc}), 16'b1_1_10_1_01);
    cyc(); #1;
    chk("bl_fetch", 16'(State), 16'd0);

    // CBNZ with Z=0 is taken
    IMReady = 1'b1; OpCode = 11'b10110101000; ALUFlags = 4'b0000; #1;
    cyc(); IMReady = 1'b0; #1;
    cyc(); #1;
    chk("cbnz_exec", 16'({PCWr, PCSrc, RegRd2Src, ALUOp, SEUScr}), 16'b1_01_1_0100_11);
    chk("cbnz_flags_held", 16'(FlagsQ), 16'b0100);
    cyc(); #1;

    // Illegal opcode traps from DECODE, then reset exits
    IMReady = 1'b1; OpCode = 11'b11110010000; #1;
    cyc(); IMReady = 1'b0; #1;
    chk("ill_decode", 16'({State, Illegal}), 16'b001_0);
    cyc(); #1;
    chk("ill_trap", 16'({State, Illegal, PCWr, RFWr}), 16'b111_1_0_0);
    cyc(); #1;
    chk("ill_trap_hold", 16'({State, FlagsQ}), 16'b111_0100);
    nRst = 1'b0; #1;
    chk("ill_reset_state", 16'({State, Illegal}), 16'b000_0);
    chk("ill_reset_flags", 16'(FlagsQ), 16'd0);
    #1 nRst = 1'b1;

    // STUR with DMReady never high times out after 15 MEM cycles
    IMReady = 1'b1; OpCode = 11'b11111000000; #1;
    cyc(); IMReady = 1'b0; #1;
    cyc(); #1;
    chk("stur_exec", 16'(State), 16'd2);
    for (int i = 0; i < 15; i++) begin
      cyc(); #1;
      chk("stur_mem_wait", 16'({State, DMWr, RegRd2Src, PCWr}), 16'b011_1_1_0);
    end
    cyc(); #1;
    chk("stur_trap", 16'({State, Illegal, DMWr, PCWr, RFWr}), 16'b111_1_0_0_0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
